sc_mem_responder: RTL

Memory-side responder for the single-cycle datapath. It serves the instruction fetch port and the data load/store port that the core drives.
- Boots in a LOAD state: accepts a valid/ready word stream that fills instruction memory while holding the core in reset.
- Then switches to RUN: releases the core and answers fetches and loads combinationally, with stores taking effect on the clock edge.

---
 rtl/sc_mem_pkg.sv | 18 +
 rtl/sc_mem_responder_ram.sv | 23 ++
 rtl/sc_mem_responder.sv | 103 ++++++++++
 3 files changed

// File: rtl/sc_mem_pkg.sv
// Shared types and constants for the single-cycle memory responder.
package sc_mem_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned IMEM_DEPTH_DEF = 32;
  localparam int unsigned DMEM_DEPTH_DEF = 256;

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_t;

  // Word aligned and inside the data RAM's byte window.
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned daddr_w);
    return (addr[1:0] == 2'b00) && ((addr >> (daddr_w + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/sc_mem_responder_ram.sv
// Plain RAM: asynchronous read, synchronous write, contents never reset.
module mod_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned DW    = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sc_mem_responder.sv
// Instruction/data memory responder: boot loader fills imem while holding
// the core in reset, then serves fetches, loads and stores.
module sc_mem_responder
  import sc_mem_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int unsigned DMEM_DEPTH = DMEM_DEPTH_DEF,
  parameter int unsigned DW         = WORD_W,
  localparam int unsigned IADDR_W   = $clog2(IMEM_DEPTH),
  localparam int unsigned DADDR_W   = $clog2(DMEM_DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IADDR_W-1:0] imem_addr_i,
  output logic [DW-1:0]      imem_out_o,
  input  logic               dmem_we_i,
  input  logic [31:0]        dmem_addr_i,
  input  logic [DW-1:0]      dmem_in_i,
  output logic [DW-1:0]      dmem_out_o,
  input  logic               ld_valid_i,
  input  logic [DW-1:0]      ld_data_i,
  input  logic               ld_last_i,
  output logic               ld_ready_o,
  output logic               ld_done_o,
  output logic               core_rst_o,
  output logic               dmem_err_o
);

  state_t             state;
  logic [IADDR_W-1:0] ld_ptr;
  logic               ld_fire;
  logic               ld_term;
  logic               d_legal;
  logic [DADDR_W-1:0] d_idx;
  logic               d_we;
  logic [DW-1:0]      imem_rdata;
  logic [DW-1:0]      dmem_rdata;

  // A beat presented while reset is asserted must not land in imem.
  assign ld_fire = (state == ST_LOAD) && ld_valid_i && ld_ready_o && !rst_i;
  assign ld_term = ld_fire && (ld_last_i || (ld_ptr == IADDR_W'(IMEM_DEPTH - 1)));

  assign d_legal = addr_legal(dmem_addr_i, DADDR_W);
  assign d_idx   = dmem_addr_i[DADDR_W+1:2];
  assign d_we    = (state == ST_RUN) && dmem_we_i && d_legal;

  mod_ram #(.DEPTH(IMEM_DEPTH), .DW(DW)) u_imem (
    .clk   (clk_i),
    .we    (ld_fire),
    .waddr (ld_ptr),
    .wdata (ld_data_i),
    .raddr (imem_addr_i),
    .rdata (imem_rdata)
  );

  mod_ram #(.DEPTH(DMEM_DEPTH), .DW(DW)) u_dmem (
    .clk   (clk_i),
    .we    (d_we),
    .waddr (d_idx),
    .wdata (dmem_in_i),
    .raddr (d_idx),
    .rdata (dmem_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_LOAD;
      ld_ptr     <= '0;
      ld_ready_o <= 1'b0;
      ld_done_o  <= 1'b0;
      core_rst_o <= 1'b1;
      dmem_err_o <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          ld_ready_o <= 1'b1;
          if (ld_fire) ld_ptr <= ld_ptr + IADDR_W'(1);
          if (ld_term) begin
            state      <= ST_RUN;
            ld_ready_o <= 1'b0;
            ld_done_o  <= 1'b1;
            core_rst_o <= 1'b0;
          end
        end
        ST_RUN: begin
          ld_ready_o <= 1'b0;
          if (dmem_we_i && !d_legal) dmem_err_o <= 1'b1;
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  always_comb begin
    imem_out_o = '0;
    dmem_out_o = '0;
    if (state == ST_RUN) begin
      if (32'(imem_addr_i) < IMEM_DEPTH) imem_out_o = imem_rdata;
      if (d_legal) dmem_out_o = dmem_rdata;
    end
  end

endmodule
